// File: rtl/ifid_if.sv
// IF/ID latch bundle: fetch and decoder inputs toward the latch, latched instruction,
// stall/bubble controls and scoreboard slots back out. The latch side uses the slave modport.
interface ifid_if;
    logic [15:0] IF_Instr;
    logic [15:0] IF_PC_Next;
    logic        IF_valid;
    logic        flush;
    logic        mem_stall;
    logic        ID_RegWrt;
    logic [2:0]  ID_RD;
    logic [2:0]  ID_RS;
    logic [2:0]  ID_RT;
    logic        ID_UsesRS;
    logic        ID_UsesRT;

    logic [15:0] IFID_Instr;
    logic [15:0] IFID_PC_Next;
    logic        IFID_valid;
    logic        ID_NOP;
    logic        PC_stall;
    logic        RegWrt_1_nflopped;
    logic [2:0]  RD_1_nflopped;
    logic        RegWrt_2_nflopped;
    logic [2:0]  RD_2_nflopped;
    logic        halted;

    modport master (
        output IF_Instr, IF_PC_Next, IF_valid, flush, mem_stall,
               ID_RegWrt, ID_RD, ID_RS, ID_RT, ID_UsesRS, ID_UsesRT,
        input  IFID_Instr, IFID_PC_Next, IFID_valid, ID_NOP, PC_stall,
               RegWrt_1_nflopped, RD_1_nflopped, RegWrt_2_nflopped, RD_2_nflopped, halted
    );

    modport slave (
        input  IF_Instr, IF_PC_Next, IF_valid, flush, mem_stall,
               ID_RegWrt, ID_RD, ID_RS, ID_RT, ID_UsesRS, ID_UsesRT,
        output IFID_Instr, IFID_PC_Next, IFID_valid, ID_NOP, PC_stall,
               RegWrt_1_nflopped, RD_1_nflopped, RegWrt_2_nflopped, RD_2_nflopped, halted
    );
endinterface

// File: rtl/ifid_latch.sv
// IF/ID register with RAW scoreboard: 1-cycle fetch-to-ID; holds on hazard or mem_stall,
// squashes on flush; ID_NOP/PC_stall are combinational from the held state.
module ifid_latch (
    input  logic   clk,
    input  logic   rst,
    ifid_if.slave  bus
);
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  HALT_OPC  = 5'b00000;

    logic [15:0] instr_q;
    logic [15:0] pc_next_q;
    logic        valid_q;
    logic        wrt1_q;
    logic [2:0]  rd1_q;
    logic        wrt2_q;
    logic [2:0]  rd2_q;
    logic        halted_q;

    logic match_rs;
    logic match_rt;
    logic hz;

    // No forwarding: any in-flight writer of a source register stalls decode.
    always_comb begin
        match_rs = (wrt1_q && (rd1_q == bus.ID_RS)) || (wrt2_q && (rd2_q == bus.ID_RS));
        match_rt = (wrt1_q && (rd1_q == bus.ID_RT)) || (wrt2_q && (rd2_q == bus.ID_RT));
        hz       = valid_q && ((bus.ID_UsesRS && match_rs) || (bus.ID_UsesRT && match_rt));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= NOP_INSTR;
            pc_next_q <= 16'h0000;
            valid_q   <= 1'b0;
            wrt1_q    <= 1'b0;
            rd1_q     <= 3'd0;
            wrt2_q    <= 1'b0;
            rd2_q     <= 3'd0;
            halted_q  <= 1'b0;
        end else if (bus.mem_stall) begin
            // EX is frozen as well and re-issues any flush once the stall clears.
            instr_q <= instr_q;
        end else if (bus.flush) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            wrt1_q  <= 1'b0;
            rd1_q   <= 3'd0;
            wrt2_q  <= wrt1_q;
            rd2_q   <= rd1_q;
        end else if (hz) begin
            wrt1_q <= 1'b0;
            rd1_q  <= 3'd0;
            wrt2_q <= wrt1_q;
            rd2_q  <= rd1_q;
        end else begin
            instr_q   <= bus.IF_Instr;
            pc_next_q <= bus.IF_PC_Next;
            valid_q   <= bus.IF_valid && !halted_q;
            wrt1_q    <= bus.ID_RegWrt && valid_q;
            rd1_q     <= bus.ID_RD;
            wrt2_q    <= wrt1_q;
            rd2_q     <= rd1_q;
            if (valid_q && (instr_q[15:11] == HALT_OPC))
                halted_q <= 1'b1;
        end
    end

    // On flush EX redirects the PC, so the PC must not be held.
    assign bus.ID_NOP   = !valid_q || bus.flush || hz;
    assign bus.PC_stall = bus.mem_stall || ((hz || halted_q) && !bus.flush);

    assign bus.IFID_Instr        = instr_q;
    assign bus.IFID_PC_Next      = pc_next_q;
    assign bus.IFID_valid        = valid_q;
    assign bus.RegWrt_1_nflopped = wrt1_q;
    assign bus.RD_1_nflopped     = rd1_q;
    assign bus.RegWrt_2_nflopped = wrt2_q;
    assign bus.RD_2_nflopped     = rd2_q;
    assign bus.halted            = halted_q;
endmodule

// File: tb/tb_ifid_latch.sv
// Directed per-cycle vectors; each cycle's expected outputs go into a queue that a
// negedge monitor pops and compares against the DUT.
module tb_ifid_latch;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifid_if bus();

    ifid_latch u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        int          tag;
        logic [15:0] instr;
        logic [15:0] pc;
        logic        v;
        logic        nop;
        logic        pcs;
        logic        w1;
        logic [2:0]  d1;
        logic        w2;
        logic [2:0]  d2;
        logic        h;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = exp_q.pop_front();
            a.tag   = e.tag;
            a.instr = bus.IFID_Instr;
            a.pc    = bus.IFID_PC_Next;
            a.v     = bus.IFID_valid;
            a.nop   = bus.ID_NOP;
            a.pcs   = bus.PC_stall;
            a.w1    = bus.RegWrt_1_nflopped;
            a.d1    = bus.RD_1_nflopped;
            a.w2    = bus.RegWrt_2_nflopped;
            a.d2    = bus.RD_2_nflopped;
            a.h     = bus.halted;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL step%0d got instr=%h pc=%h v=%b nop=%b pcs=%b s1=%b/%0d s2=%b/%0d h=%b need instr=%h pc=%h v=%b nop=%b pcs=%b s1=%b/%0d s2=%b/%0d h=%b",
                         e.tag, a.instr, a.pc, a.v, a.nop, a.pcs, a.w1, a.d1, a.w2, a.d2, a.h,
                         e.instr, e.pc, e.v, e.nop, e.pcs, e.w1, e.d1, e.w2, e.d2, e.h);
            end
        end
    end

    task automatic drive(input logic r, input logic [15:0] ins, input logic [15:0] pc,
                         input logic iv, input logic fl, input logic ms);
        rst            = r;
        bus.IF_Instr   = ins;
        bus.IF_PC_Next = pc;
        bus.IF_valid   = iv;
        bus.flush      = fl;
        bus.mem_stall  = ms;
    endtask

    task automatic dec(input logic rw, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic urs, input logic urt);
        bus.ID_RegWrt = rw;
        bus.ID_RD     = rd;
        bus.ID_RS     = rs;
        bus.ID_RT     = rt;
        bus.ID_UsesRS = urs;
        bus.ID_UsesRT = urt;
    endtask

    // Push what this cycle must show, then advance past the next rising edge.
    task automatic chk(input logic [15:0] instr, input logic [15:0] pc, input logic v,
                       input logic nop, input logic pcs, input logic w1, input logic [2:0] d1,
                       input logic w2, input logic [2:0] d2, input logic h);
        exp_t e;
        e.tag = step_no; e.instr = instr; e.pc = pc; e.v = v; e.nop = nop; e.pcs = pcs;
        e.w1 = w1; e.d1 = d1; e.w2 = w2; e.d2 = d2; e.h = h;
        exp_q.push_back(e);
        step_no++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1, 16'hA001, 16'h0002, 1, 0, 0); dec(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        // reset held a second cycle with IF_valid=1
        drive(1, 16'hA001, 16'h0002, 1, 0, 0);
        chk(16'h0800, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0);
        // back-to-back RAW: producer r1, then reader of r1
        drive(0, 16'hA001, 16'h0002, 1, 0, 0); dec(0, 0, 0, 0, 0, 0);
        chk(16'h0800, 16'h0000, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 16'hB012, 16'h0004, 1, 0, 0); dec(1, 1, 2, 3, 0, 0);
        chk(16'hA001, 16'h0002, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 16'hC000, 16'h0006, 1, 0, 0); dec(1, 2, 1, 3, 1, 1);
        chk(16'hB012, 16'h0004, 1, 1, 1, 1, 1, 0, 0, 0);
        chk(16'hB012, 16'h0004, 1, 1, 1, 0, 0, 1, 1, 0);
        chk(16'hB012, 16'h0004, 1, 0, 0, 0, 0, 0, 0, 0);
        // distance-2 RAW through RT
        drive(0, 16'hD000, 16'h0008, 1, 0, 0); dec(1, 4, 0, 0, 0, 0);
        chk(16'hC000, 16'h0006, 1, 0, 0, 1, 2, 0, 0, 0);
        drive(0, 16'hE000, 16'h000A, 1, 0, 0); dec(0, 5, 6, 7, 1, 1);
        chk(16'hD000, 16'h0008, 1, 0, 0, 1, 4, 1, 2, 0);
        drive(0, 16'hF000, 16'h000C, 1, 0, 0); dec(1, 3, 0, 4, 0, 1);
        chk(16'hE000, 16'h000A, 1, 1, 1, 0, 5, 1, 4, 0);
        chk(16'hE000, 16'h000A, 1, 0, 0, 0, 0, 0, 5, 0);
        // flush coincident with hazard
        drive(0, 16'hA100, 16'h000E, 1, 1, 0); dec(1, 6, 3, 0, 1, 0);
        chk(16'hF000, 16'h000C, 1, 1, 0, 1, 3, 0, 0, 0);
        drive(0, 16'hA200, 16'h0014, 1, 0, 0); dec(0, 0, 0, 0, 0, 0);
        chk(16'h0800, 16'h000C, 0, 1, 0, 0, 0, 1, 3, 0);
        // mem_stall for 3 cycles during a hazard, flush pulsed in the middle
        drive(0, 16'hA300, 16'h0016, 1, 0, 0); dec(1, 5, 0, 0, 0, 0);
        chk(16'hA200, 16'h0014, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 16'hA400, 16'h0018, 1, 0, 1); dec(0, 0, 5, 0, 1, 0);
        chk(16'hA300, 16'h0016, 1, 1, 1, 1, 5, 0, 0, 0);
        drive(0, 16'hA400, 16'h0018, 1, 1, 1);
        chk(16'hA300, 16'h0016, 1, 1, 1, 1, 5, 0, 0, 0);
        drive(0, 16'hA400, 16'h0018, 1, 0, 1);
        chk(16'hA300, 16'h0016, 1, 1, 1, 1, 5, 0, 0, 0);
        drive(0, 16'hA400, 16'h0018, 1, 0, 0);
        chk(16'hA300, 16'h0016, 1, 1, 1, 1, 5, 0, 0, 0);
        chk(16'hA300, 16'h0016, 1, 1, 1, 0, 0, 1, 5, 0);
        drive(0, 16'h0000, 16'h0018, 1, 0, 0);
        chk(16'hA300, 16'h0016, 1, 0, 0, 0, 0, 0, 0, 0);
        // HALT squashed by flush
        drive(0, 16'hA500, 16'h001A, 1, 1, 0); dec(0, 0, 0, 0, 0, 0);
        chk(16'h0000, 16'h0018, 1, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 16'hA600, 16'h001E, 1, 0, 0);
        chk(16'h0800, 16'h0018, 0, 1, 0, 0, 0, 0, 0, 0);
        // writer then real HALT; fetch bubble on the halt edge
        drive(0, 16'h0000, 16'h0020, 1, 0, 0); dec(1, 7, 0, 0, 0, 0);
        chk(16'hA600, 16'h001E, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 16'hA700, 16'h0022, 0, 0, 0); dec(0, 0, 0, 0, 0, 0);
        chk(16'h0000, 16'h0020, 1, 0, 0, 1, 7, 0, 0, 0);
        drive(0, 16'hA800, 16'h0024, 1, 0, 0);
        chk(16'hA700, 16'h0022, 0, 1, 1, 0, 0, 1, 7, 1);
        drive(0, 16'hA900, 16'h0026, 1, 0, 0);
        chk(16'hA800, 16'h0024, 0, 1, 1, 0, 0, 0, 0, 1);
        drive(0, 16'hAA00, 16'h0028, 1, 1, 0);
        chk(16'hA900, 16'h0026, 0, 1, 0, 0, 0, 0, 0, 1);
        drive(0, 16'hAB00, 16'h002A, 1, 0, 0);
        chk(16'h0800, 16'h0026, 0, 1, 1, 0, 0, 0, 0, 1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries never compared, need 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifid_latch.md
# ifid_latch

IF/ID pipeline register for the 16-bit five-stage core, combined with the decode-stage RAW hazard scoreboard. It captures the fetched instruction and its PC+2. It holds them on a data hazard or a memory stall, and squashes them on a taken branch or jump redirect. It tracks the destination registers of the two instructions ahead of decode and exports them as the `*_1_nflopped` / `*_2_nflopped` signals. The core has no forwarding paths; the register file writes through to reads in the same cycle, so WB needs no tracking.

## Interface
- NOP_INSTR, 16'h0800, encoding loaded into IFID_Instr on reset and on flush
- HALT_OPC, 5'b00000, opcode (bits [15:11]) that marks HALT
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- IF_Instr  in  16  fetched instruction
- IF_PC_Next  in  16  PC+2 of the fetched instruction
- IF_valid  in  1  instruction memory returned a valid word this cycle
- flush  in  1  EX resolved a taken branch or jump; squash the instruction in ID
- mem_stall  in  1  data or instruction memory busy; freeze this block
- ID_RegWrt  in  1  decoder: the instruction in ID writes a register
- ID_RD / ID_RS / ID_RT  in  3 each  decoder register fields
- ID_UsesRS / ID_UsesRT  in  1 each  decoder: the operand is actually read
- IFID_Instr  out  16  latched instruction
- IFID_PC_Next  out  16  latched PC+2
- IFID_valid  out  1  latched instruction is real
- ID_NOP  out  1  combinational; IDEX must capture a bubble
- PC_stall  out  1  combinational; PC register must hold
- RegWrt_1_nflopped / RD_1_nflopped  out  1 / 3  scoreboard slot 1 (instruction in EX)
- RegWrt_2_nflopped / RD_2_nflopped  out  1 / 3  scoreboard slot 2 (instruction in MEM)
- halted  out  1  HALT has issued; the front end is frozen

## Operation
- Hazard definition:
  - `hz = IFID_valid & ((ID_UsesRS & match(ID_RS)) | (ID_UsesRT & match(ID_RT)))`.
  - `match(r) = (RegWrt_1 & RD_1==r) | (RegWrt_2 & RD_2==r)`.
  - R0 has no special case.
- Per-edge priority: rst > mem_stall > flush > hz > normal.
- rst:
  - IFID_Instr=NOP_INSTR; IFID_PC_Next=0; IFID_valid=0.
  - Both scoreboard slots=0; halted=0.
- mem_stall: every register holds, and flush is ignored. EX is frozen too and re-asserts flush after the stall clears.
- flush:
  - IFID_Instr=NOP_INSTR, IFID_valid=0.
  - slot1 <= 0 (bubble); slot2 <= slot1.
  - A HALT in IFID is squashed and does not set halted.
- hz:
  - IFID holds its contents.
  - slot1 <= 0 (bubble); slot2 <= slot1.
- normal:
  - IFID <= {IF_Instr, IF_PC_Next}; IFID_valid <= IF_valid & ~halted.
  - slot1 <= {ID_RegWrt & IFID_valid, ID_RD}; slot2 <= slot1.
  - If IFID_valid and IFID_Instr[15:11]==HALT_OPC, set halted.
- After halted=1:
  - IFID_valid is captured as 0 on every edge.
  - PC_stall stays at 1.
  - The scoreboard keeps shifting, so in-flight writers drain.
- Combinational outputs:
  - `ID_NOP = ~IFID_valid | flush | hz`.
  - `PC_stall = mem_stall | ((hz | halted) & ~flush)`.
  - On flush, EX owns the PC redirect, so PC_stall deasserts.

## Timing
- Fetch-to-ID latency: 1 cycle.
- A dependent instruction directly behind its producer stalls 2 cycles: the producer sits in slot1, then in slot2. The consumer issues on the 3rd cycle, when the producer is in WB.
- A consumer 2 instructions behind its producer stalls 1 cycle. One 3 or more behind does not stall.
- Simultaneous flush and hz: flush wins and PC_stall=0.
- Simultaneous flush and mem_stall: all registers hold.
- IF_valid=0 with no stall: IFID_valid=0 on the next cycle and a bubble propagates.
- All outputs are defined in the cycle after rst is released. ID_NOP=1 and PC_stall=0 until the first valid fetch.

## Test plan
- Reset:
  - Stimulus: assert rst for 2 cycles with IF_valid=1.
  - Required: IFID_Instr=16'h0800, IFID_valid=0, all slots 0, halted=0, ID_NOP=1.
- Back-to-back RAW:
  - Stimulus: ADD r1 (RegWrt=1, RD=1), then ADD r2,r1,r3 (UsesRS, RS=1).
  - Required: ID_NOP=1 and PC_stall=1 for exactly 2 cycles.
  - Required: RD_1_nflopped=1 then RD_2_nflopped=1; the consumer issues on cycle 3.
- Distance-2 RAW:
  - Stimulus: a producer of r4, an independent instruction, then a reader of r4 via RT.
  - Required: 1 stall cycle.
- Flush during hazard:
  - Stimulus: assert flush and hz in the same cycle.
  - Required: next IFID_valid=0, IFID_Instr=16'h0800, PC_stall=0, slot1=0.
- mem_stall freeze:
  - Stimulus: assert mem_stall for 3 cycles during a hazard, with flush pulsed on cycle 2.
  - Required: IFID, both slots and halted unchanged throughout; the flush has no effect.
- Halt:
  - Stimulus: valid 16'h0000 enters IFID with no hazard.
  - Required: halted=1 on the next edge; IFID_valid then stays 0 and PC_stall stays 1.
  - Required: slots drain to 0 within 2 cycles.
  - Stimulus (squash case): flush asserted in the cycle HALT sits in IFID.
  - Required: halted stays 0.
